// File: rtl/common_pkg.sv
// Shared types and helpers for grant/arbitration blocks: decoder FSM states and
// an index-to-one-hot expansion usable by any block up to OH_MAX_W requesters.
package common_pkg;

  typedef enum logic {
    GD_IDLE  = 1'b0,
    GD_GRANT = 1'b1
  } gd_state_t;

  localparam int unsigned OH_MAX_W = 256;

  // Callers truncate the result to their own requester count.
  function automatic logic [OH_MAX_W-1:0] onehot_of(input logic [31:0] idx);
    logic [OH_MAX_W-1:0] oh;
    oh = '0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      oh[i] = (idx == 32'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// Encoded index -> registered one-hot grant, held until the owner acks it.
// Optional forced release after TIMEOUT cycles when GRANT_TIMEOUT_EN is defined.
module grant_decoder
  import common_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int TIMEOUT = 16,
  localparam int IDX_W   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idx_valid,
  output logic             idx_ready,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  input  logic [WIDTH-1:0] ack,
  output logic             done,
  output logic             err,
  output logic             timeout
);

  gd_state_t        r_state;
  logic [WIDTH-1:0] r_grant_oh;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_done;
  logic             r_err;

  logic             w_idx_ok;
  logic [WIDTH-1:0] w_oh;
  logic             w_ack_hit;

  // Out-of-range indices only exist when WIDTH is not a power of two.
  assign w_idx_ok  = (32'(idx) < 32'(WIDTH));
  assign w_oh      = WIDTH'(onehot_of(32'(idx)));
  assign w_ack_hit = ack[r_grant_idx];

  assign idx_ready = (r_state == GD_IDLE);
  assign grant_oh  = r_grant_oh;
  assign grant_idx = r_grant_idx;
  assign done      = r_done;
  assign err       = r_err;

`ifdef GRANT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_expire;

  assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout  = r_timeout;
`else
  assign timeout  = 1'b0;
`endif

  // Grant FSM: accept in IDLE, release on matching ack (ack wins over expiry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= GD_IDLE;
      r_grant_oh  <= '0;
      r_grant_idx <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        GD_IDLE: begin
          if (idx_valid) begin
            if (w_idx_ok) begin
              r_grant_oh  <= w_oh;
              r_grant_idx <= idx;
              r_state     <= GD_GRANT;
`ifdef GRANT_TIMEOUT_EN
              r_cnt       <= '0;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_state <= GD_IDLE;
          end
        end
        GD_GRANT: begin
          if (w_ack_hit) begin
            r_grant_oh <= '0;
            r_done     <= 1'b1;
            r_state    <= GD_IDLE;
`ifdef GRANT_TIMEOUT_EN
          end else if (w_expire) begin
            r_grant_oh <= '0;
            r_timeout  <= 1'b1;
            r_state    <= GD_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`else
          end else begin
            r_state <= GD_GRANT;
          end
`endif
        end
        default: begin
          r_state    <= GD_IDLE;
          r_grant_oh <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_decoder.sv
// Randomized + directed bench for grant_decoder: a WIDTH=32 instance (TIMEOUT=4)
// and a WIDTH=5 instance for out-of-range indices, both checked against an owner model.
module tb_grant_decoder;

  localparam int WA   = 32;
  localparam int WB   = 5;
  localparam int TO_A = 4;
  localparam int TO_B = 16;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        va, ra, da, ea, ta;
  logic [4:0]  ia, gia;
  logic [31:0] aa, goa;
  logic        vb, rb, db, eb, tb2;
  logic [2:0]  ib, gib;
  logic [4:0]  ab, gob;

  grant_decoder #(.WIDTH(WA), .TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .idx_valid(va), .idx_ready(ra), .idx(ia),
    .grant_oh(goa), .grant_idx(gia), .ack(aa), .done(da), .err(ea), .timeout(ta)
  );

  grant_decoder #(.WIDTH(WB), .TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .idx_valid(vb), .idx_ready(rb), .idx(ib),
    .grant_oh(gob), .grant_idx(gib), .ack(ab), .done(db), .err(eb), .timeout(tb2)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: who owns the grant (-1 = nobody), how long, and this cycle's pulses.
  int own[2];
  int age[2];
  bit e_done[2], e_err[2], e_to[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; age[d] = 0; e_done[d] = 1'b0; e_err[d] = 1'b0; e_to[d] = 1'b0;
    end
  endtask

  task automatic model_adv(input int d, input bit v, input int i, input int w,
                           input int tmo, input logic [31:0] a);
    e_done[d] = 1'b0; e_err[d] = 1'b0; e_to[d] = 1'b0;
    if (own[d] < 0) begin
      if (v) begin
        if (i < w) begin own[d] = i; age[d] = 0; end
        else e_err[d] = 1'b1;
      end
    end else if (a[own[d]]) begin
      e_done[d] = 1'b1; own[d] = -1;
    end else if (TO_EN && age[d] == tmo - 1) begin
      e_to[d] = 1'b1; own[d] = -1;
    end else begin
      age[d]++;
    end
  endtask

  function automatic logic [31:0] exp_oh(input int d);
    return (own[d] < 0) ? 32'h0 : (32'h1 << own[d]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a_grant_oh", goa, exp_oh(0));
    chk("a_ready", {31'h0, ra}, {31'h0, (own[0] < 0)});
    chk("a_done", {31'h0, da}, {31'h0, e_done[0]});
    chk("a_err", {31'h0, ea}, {31'h0, e_err[0]});
    chk("a_timeout", {31'h0, ta}, {31'h0, e_to[0]});
    chk("a_popcount", 32'($countones(goa)) <= 32'd1 ? 32'h1 : 32'h0, 32'h1);
    if (own[0] >= 0) chk("a_grant_idx", {27'h0, gia}, 32'(own[0]));
    chk("b_grant_oh", {27'h0, gob}, exp_oh(1));
    chk("b_ready", {31'h0, rb}, {31'h0, (own[1] < 0)});
    chk("b_done", {31'h0, db}, {31'h0, e_done[1]});
    chk("b_err", {31'h0, eb}, {31'h0, e_err[1]});
    chk("b_timeout", {31'h0, tb2}, {31'h0, e_to[1]});
    if (own[1] >= 0) chk("b_grant_idx", {29'h0, gib}, 32'(own[1]));
  endtask

  // Advance one clock: predict from the current inputs, then check #1 after the edge.
  task automatic step();
    model_adv(0, va, int'(ia), WA, TO_A, aa);
    model_adv(1, vb, int'(ib), WB, TO_B, {27'h0, ab});
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0;
    va = 1'b0; ia = '0; aa = '0;
    vb = 1'b0; ib = '0; ab = '0;
    model_reset();
    #12;
    compare_all();
    chk("reset_ready", {31'h0, ra}, 32'h1);
    chk("reset_grant_idx", {27'h0, gia}, 32'h0);
    rst_n = 1'b1;

    // Grant idx 5, foreign ack ignored, matching ack releases.
    va = 1'b1; ia = 5'd5;
    step();
    chk("lit_grant5", goa, 32'h0000_0020);
    chk("lit_grant5_idx", {27'h0, gia}, 32'd5);
    chk("lit_busy", {31'h0, ra}, 32'h0);
    va = 1'b0; aa = 32'h0000_0008;
    step();
    chk("lit_ack3_hold", goa, 32'h0000_0020);
    aa = 32'h0000_0020;
    step();
    chk("lit_ack5_done", {31'h0, da}, 32'h1);
    chk("lit_ack5_clear", goa, 32'h0);
    aa = '0;
    step();
    chk("lit_done_pulse", {31'h0, da}, 32'h0);
    chk("lit_ready_again", {31'h0, ra}, 32'h1);

    // Back-to-back: ack of idx 0 while idx 31 is already offered.
    va = 1'b1; ia = 5'd0;
    step();
    aa = 32'h1; ia = 5'd31;
    step();
    chk("lit_b2b_gap", goa, 32'h0);
    aa = '0;
    step();
    chk("lit_b2b_grant31", goa, 32'h8000_0000);
    va = 1'b0; aa = 32'h8000_0000;
    step();
    aa = '0;

    // WIDTH=5: index 6 is rejected.
    vb = 1'b1; ib = 3'd6;
    step();
    chk("lit_err_pulse", {31'h0, eb}, 32'h1);
    chk("lit_err_nogrant", {27'h0, gob}, 32'h0);
    chk("lit_err_ready", {31'h0, rb}, 32'h1);
    vb = 1'b0;
    step();
    chk("lit_err_once", {31'h0, eb}, 32'h0);

    // Unacknowledged grant: forced release after TIMEOUT cycles, or held forever.
    va = 1'b1; ia = 5'd9;
    step();
    va = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lit_to_held", goa, 32'h0000_0200);
    end
    step();
    if (TO_EN) begin
      chk("lit_to_drop", goa, 32'h0);
      chk("lit_to_pulse", {31'h0, ta}, 32'h1);
      chk("lit_to_nodone", {31'h0, da}, 32'h0);
      va = 1'b1; ia = 5'd9;
      step();
      va = 1'b0;
      for (int k = 0; k < 3; k++) step();
      aa = 32'h0000_0200;
      step();
      chk("lit_ack4_done", {31'h0, da}, 32'h1);
      chk("lit_ack4_noto", {31'h0, ta}, 32'h0);
      aa = '0;
    end else begin
      for (int k = 0; k < 8; k++) step();
      chk("lit_no_to_held", goa, 32'h0000_0200);
      chk("lit_no_to_pulse", {31'h0, ta}, 32'h0);
      aa = 32'h0000_0200;
      step();
      aa = '0;
    end
    step();

    // Asynchronous reset in the middle of a grant.
    va = 1'b1; ia = 5'd7;
    step();
    va = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("lit_arst_clear", goa, 32'h0);
    chk("lit_arst_nodone", {31'h0, da}, 32'h0);
    chk("lit_arst_ready", {31'h0, ra}, 32'h1);
    model_reset();
    #1 rst_n = 1'b1;
    va = 1'b1; ia = 5'd3;
    step();
    chk("lit_post_rst_grant", goa, 32'h0000_0008);
    va = 1'b0; aa = 32'h0000_0008;
    step();
    aa = '0;

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      va = 1'($urandom_range(0, 1));
      ia = 5'($urandom);
      aa = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h0;
      vb = 1'($urandom_range(0, 1));
      ib = 3'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
